// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the ysyx_22041211 MEM stage: store/load types, LSU FSM states,
// and the alignment rule used at accept time.
package ysyx_22041211_lsu_pkg;

  localparam logic [1:0] STORE_NONE = 2'b00;
  localparam logic [1:0] STORE_SB   = 2'b01;
  localparam logic [1:0] STORE_SH   = 2'b10;
  localparam logic [1:0] STORE_SW   = 2'b11;

  localparam logic [2:0] LOAD_NONE  = 3'b000;
  localparam logic [2:0] LOAD_LB    = 3'b001;
  localparam logic [2:0] LOAD_LBU   = 3'b010;
  localparam logic [2:0] LOAD_LH    = 3'b011;
  localparam logic [2:0] LOAD_LHU   = 3'b100;
  localparam logic [2:0] LOAD_LW    = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_RESP = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  function automatic logic load_valid(input logic [2:0] lt);
    return (lt >= LOAD_LB) && (lt <= LOAD_LW);
  endfunction

  // Stores take precedence over any load_type that accompanies them.
  function automatic logic misaligned(input logic [1:0] st, input logic [2:0] lt,
                                      input logic [1:0] off);
    logic m;
    m = 1'b0;
    if (st != STORE_NONE) begin
      case (st)
        STORE_SH: m = off[0];
        STORE_SW: m = (off != 2'b00);
        default:  m = 1'b0;
      endcase
    end else begin
      case (lt)
        LOAD_LH, LOAD_LHU: m = off[0];
        LOAD_LW:           m = (off != 2'b00);
        default:           m = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_load_align.sv
// Read-data lane select and sign/zero extension for loads.
module ysyx_22041211_load_align
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [DATA_LEN-1:0] rdata_i,
  input  logic [1:0]          off_i,
  input  logic [2:0]          load_type_i,
  output logic [DATA_LEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (off_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (load_type_i)
      LOAD_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: data_o = {24'b0, byte_sel};
      LOAD_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: data_o = {16'b0, half_sel};
      LOAD_LW:  data_o = rdata_i;
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// MEM stage: latches one EXE packet, runs at most one bus transaction for it and
// hands a registered writeback packet to WB under valid/ready.
module ysyx_22041211_lsu
  import ysyx_22041211_lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exe_valid_i,
  output logic                lsu_ready_o,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [1:0]          store_type_i,
  input  logic [2:0]          load_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_wdata_o,
  output logic [3:0]          mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_LEN-1:0] mem_rdata_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic                wb_wd_o,
  output logic [4:0]          wb_wreg_o,
  output logic [DATA_LEN-1:0] wb_wdata_o,
  output logic                misalign_o
);

  lsu_state_e          state_q, state_d;
  logic                we_q, we_d;
  logic [DATA_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] sdata_q, sdata_d;
  logic [3:0]          mask_q, mask_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          ltype_q, ltype_d;
  logic                is_st_q, is_st_d;
  logic                wd_q, wd_d;
  logic [4:0]          wreg_q, wreg_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic                mis_q, mis_d;

  logic                accept, in_st, in_ld, in_mis;
  logic [DATA_LEN-1:0] ld_data;

  assign lsu_ready_o = (state_q == LSU_IDLE) || ((state_q == LSU_DONE) && wb_ready_i);
  assign accept      = exe_valid_i && lsu_ready_o;
  assign in_st       = (store_type_i != STORE_NONE);
  assign in_ld       = !in_st && load_valid(load_type_i);
  assign in_mis      = (in_st || in_ld) && misaligned(store_type_i, load_type_i, alu_result_i[1:0]);

  ysyx_22041211_load_align #(.DATA_LEN(DATA_LEN)) u_load_align (
    .rdata_i     (mem_rdata_i),
    .off_i       (off_q),
    .load_type_i (ltype_q),
    .data_o      (ld_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    mask_d  = mask_q;
    off_d   = off_q;
    ltype_d = ltype_q;
    is_st_d = is_st_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;

    case (state_q)
      LSU_REQ:  if (mem_gnt_i) state_d = LSU_RESP;
      LSU_RESP: if (mem_rvalid_i) begin
        state_d = LSU_DONE;
        if (!is_st_q) wdata_d = ld_data;
      end
      LSU_DONE: if (wb_ready_i) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase

    // A new packet overrides the DONE->IDLE step so WB sees no bubble.
    if (accept) begin
      off_d   = alu_result_i[1:0];
      ltype_d = load_type_i;
      is_st_d = in_st;
      wreg_d  = wreg_i;
      if (in_mis) begin
        state_d = LSU_DONE;
        wd_d    = 1'b0;
        wdata_d = '0;
        mis_d   = 1'b1;
      end else begin
        state_d = (in_st || in_ld) ? LSU_REQ : LSU_DONE;
        wd_d    = wd_i;
        wdata_d = alu_result_i;
        mis_d   = 1'b0;
        if (in_st || in_ld) begin
          we_d    = in_st;
          addr_d  = {alu_result_i[DATA_LEN-1:2], 2'b00};
          sdata_d = '0;
          mask_d  = 4'b0000;
          case (store_type_i)
            STORE_SB: begin
              sdata_d = {4{mem_wdata_i[7:0]}};
              mask_d  = 4'b0001 << alu_result_i[1:0];
            end
            STORE_SH: begin
              sdata_d = {2{mem_wdata_i[15:0]}};
              mask_d  = 4'b0011 << alu_result_i[1:0];
            end
            STORE_SW: begin
              sdata_d = mem_wdata_i;
              mask_d  = 4'b1111;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sdata_q <= '0;
      mask_q  <= 4'b0000;
      off_q   <= 2'b00;
      ltype_q <= LOAD_NONE;
      is_st_q <= 1'b0;
      wd_q    <= 1'b0;
      wreg_q  <= 5'd0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
      ltype_q <= ltype_d;
      is_st_q <= is_st_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  assign mem_req_o   = (state_q == LSU_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = sdata_q;
  assign mem_wmask_o = mask_q;
  assign wb_valid_o  = (state_q == LSU_DONE);
  assign wb_wd_o     = wd_q;
  assign wb_wreg_o   = wreg_q;
  assign wb_wdata_o  = wdata_q;
  assign misalign_o  = wb_valid_o && mis_q;

endmodule
